inst_mem: RTL and testbench
===========================

# inst_mem

Instruction memory responder for the MIPS CPU: it answers the fetch stage's `pc`/`romCe` requests with a registered 32-bit instruction one cycle later. It also contains a byte-stream program loader that fills the memory before or between runs. While a load is in progress, fetches are held off.

## Interface
- `PC_LENGTH`, 32, fetch address width in bits (shared header value)
- `ADDR_WIDTH`, 10, word-address width; depth = 2^ADDR_WIDTH words
- `clk` input 1: single clock; all state changes on the rising edge
- `rst` input 1: reset, asynchronous, active-low
- `pc` input PC_LENGTH: byte address of the requested instruction
- `romCe` input 1: fetch enable, high = request
- `inst` output 32: fetched instruction word
- `instValid` output 1: `inst` holds a served fetch
- `instErr` output 1: the last served fetch was misaligned or out of range
- `ldStart` input 1: one-cycle pulse; begins a program load at word 0
- `ldValid` input 1: `ldByte` is presented
- `ldByte` input 8: program byte, big-endian within each word
- `ldLast` input 1: qualifies the final byte of the program
- `ldReady` output 1: the loader accepts bytes (high only in LOAD)
- `busy` output 1: high whenever the state is not IDLE
- `ldOvf` output 1: sticky flag; a load word fell beyond the depth

## Operation
- Storage: 2^ADDR_WIDTH × 32 bit array. Reset does not clear it.
- Word index = `pc[ADDR_WIDTH+1:2]`.
  - Misaligned: `pc[1:0] != 0`.
  - Out of range: `pc[PC_LENGTH-1:ADDR_WIDTH+2] != 0`.
  - Either condition: `inst` <= 0 (NOP), `instValid` <= 1, `instErr` <= 1.
- FSM states: IDLE and LOAD.
- IDLE:
  - Edge with `romCe`=1: `inst` <= mem[idx], `instValid` <= 1, `instErr` <= 0.
  - Edge with `romCe`=0: `inst` <= 0, `instValid` <= 0, `instErr` <= 0.
  - `ldStart`=1 moves to LOAD and clears the load address, byte count, shift register and `ldOvf`.
- LOAD:
  - `ldReady`=1. A byte is accepted on any edge with `ldValid`=1.
  - Each byte shifts into the shift register MSB-first: word = {b0,b1,b2,b3}.
  - On the 4th byte, the word is written to mem[ldAddr] and ldAddr increments.
  - `ldLast` accepted on byte k<3: the remaining low bytes are zero-filled, the word is written, and the state returns to IDLE.
  - `ldLast` accepted on byte 3: normal write, then return to IDLE.
  - Word write with ldAddr = depth: the write is discarded and `ldOvf` <= 1. ldAddr saturates and does not wrap.
  - Fetches in LOAD are not served: `inst` <= 0, `instValid` <= 0.
  - `ldStart` in LOAD is ignored.
- Simultaneous `ldStart` and `romCe` in IDLE: the fetch is served from the pre-load contents, then the state enters LOAD.
- Reset, asynchronous, including mid-load:
  - State = IDLE; `inst`, `instValid`, `instErr`, `ldReady`, `busy`, `ldOvf` = 0.
  - Counters and shift register = 0.
  - A partial word is discarded; words already written are kept.

## Timing
- Fetch latency: exactly 1 cycle. `pc` sampled at edge N appears on `inst` after edge N. Back-to-back fetches run at 1 per cycle.
- `busy`, `ldReady`: registered. Both rise the cycle after the `ldStart` edge and fall the cycle after the edge that accepts `ldLast`.
- Write latency: a memory word written at edge N is readable by a fetch sampled at edge N+1 or later. No read/write collision is possible, because fetches are blocked in LOAD.
- Load throughput: 1 byte per cycle. `ldValid` may idle any number of cycles without losing state.
- `ldOvf` rises the cycle after the discarded write and holds until the next `ldStart` or reset.

## Structure
- The shared header `MIPS.vh` holds `PC_LENGTH`, `PC_STEP`, `ENABLE`/`DISABLE`, the instruction width (32) and the NOP encoding (0).
- The FSM state encodings stay local to the block.
- One natural sub-module: `inst_loader`. It holds the FSM, byte counter, shift register, ldAddr and overflow flag, and drives a word write port (we, waddr, wdata) into the array in `inst_mem`.

## Test plan
- Load bytes 0x24,0x01,0x00,0x05, 0x00,0x00,0x00,0x00 with `ldLast` on the last byte. Then fetch pc=0,4 → inst 0x24010005, 0x00000000; `instValid`=1 one cycle after each request.
- `ldLast` on the 2nd byte (0xAB,0xCD) → mem[0]=0xABCD0000; `busy` falls the next cycle.
- Fetch pc=0x2, and pc=1<<(ADDR_WIDTH+2) → inst 0, `instValid`=1, `instErr`=1. Then pc=0 → `instErr`=0.
- `romCe` held high during LOAD → `instValid`=0 throughout. Same-edge `ldStart`+fetch → the old word is returned once.
- Load 4·(depth+1) bytes → first depth words correct, `ldOvf`=1. `ldOvf` clears on the next `ldStart`.
- Assert `rst` low after 6 bytes → all outputs 0 immediately. mem[0] is retained; mem[1] is unchanged from its prior contents.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// Shared MIPS constants for the instruction memory and its program loader.
// Holds fetch-address width, PC step, enable levels, instruction width and NOP.
// Also provides the byte-placement helper used to assemble big-endian words.
package inst_mem_pkg;

  localparam int MIPS_PC_LENGTH = 32;
  localparam int MIPS_PC_STEP   = 4;
  localparam int INST_WIDTH     = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [INST_WIDTH-1:0] MIPS_NOP = '0;

  // Place a byte into a word at big-endian lane idx (0 = most significant).
  function automatic logic [INST_WIDTH-1:0] place_byte(
    input logic [INST_WIDTH-1:0] word,
    input logic [7:0]            b,
    input logic [1:0]            idx
  );
    logic [4:0] shamt;
    // Lane idx sits (3 - idx) bytes above the LSB; for 2 bits, 3 - idx == ~idx.
    shamt = {~idx, 3'b000};
    return word | (INST_WIDTH'(b) << shamt);
  endfunction

endpackage

// File: rtl/inst_loader.sv
// Byte-stream program loader: packs bytes MSB-first into words and writes them from word 0 up.
// Latency: a word is written on the edge accepting its 4th byte (or the ldLast byte).
// Backpressure: ld_ready is high for the whole LOAD state, so one byte per cycle is always accepted.
module inst_loader
  import inst_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_byte,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  busy,
  output logic                  ld_ovf,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [INST_WIDTH-1:0] wdata
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  // One past the last word; the address counter stops here instead of wrapping.
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [INST_WIDTH-1:0] shift_q, shift_d;
  logic [ADDR_WIDTH:0]   ld_addr_q, ld_addr_d;
  logic                  ovf_q, ovf_d;
  logic [INST_WIDTH-1:0] word_n;

  // Next-state, byte packing and word write-port decode.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    ld_addr_d  = ld_addr_q;
    ovf_d      = ovf_q;
    we         = DISABLE;
    waddr      = ld_addr_q[ADDR_WIDTH-1:0];
    wdata      = MIPS_NOP;
    // Low lanes not yet filled are still zero, which gives the zero-fill on an early ldLast.
    word_n     = place_byte(shift_q, ld_byte, byte_cnt_q);

    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          state_d    = ST_LOAD;
          byte_cnt_d = '0;
          shift_d    = '0;
          ld_addr_d  = '0;
          ovf_d      = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          if (byte_cnt_q == 2'd3 || ld_last) begin
            if (ld_addr_q == DEPTH) begin
              ovf_d = 1'b1;
            end else begin
              we        = ENABLE;
              wdata     = word_n;
              ld_addr_d = ld_addr_q + 1'b1;
            end
            shift_d    = '0;
            byte_cnt_d = '0;
            if (ld_last) begin
              state_d = ST_IDLE;
            end
          end else begin
            shift_d    = word_n;
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Loader state registers; reset drops any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      ld_addr_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      ld_addr_q  <= ld_addr_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ld_ready = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_IDLE);
  assign ld_ovf   = ovf_q;

endmodule

// File: rtl/inst_mem.sv
// Instruction memory: serves pc/romCe fetches with a registered word, filled by inst_loader.
// Latency: 1 cycle from the sampling edge to inst/instValid; one fetch per cycle.
// Backpressure: no fetch is served while a load is running (instValid stays low).
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int PC_LENGTH  = MIPS_PC_LENGTH,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_LENGTH-1:0]  pc,
  input  logic                  romCe,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  instValid,
  output logic                  instErr,
  input  logic                  ldStart,
  input  logic                  ldValid,
  input  logic [7:0]            ldByte,
  input  logic                  ldLast,
  output logic                  ldReady,
  output logic                  busy,
  output logic                  ldOvf
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [INST_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [INST_WIDTH-1:0] mem_wdata;

  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  inst_valid_q, inst_valid_d;
  logic                  inst_err_q, inst_err_d;

  logic [ADDR_WIDTH-1:0] fetch_idx;
  logic                  misaligned;
  logic                  out_of_range;

  inst_loader #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_loader (
    .clk      (clk),
    .rst      (rst),
    .ld_start (ldStart),
    .ld_valid (ldValid),
    .ld_byte  (ldByte),
    .ld_last  (ldLast),
    .ld_ready (ldReady),
    .busy     (busy),
    .ld_ovf   (ldOvf),
    .we       (mem_we),
    .waddr    (mem_waddr),
    .wdata    (mem_wdata)
  );

  // Program storage write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign fetch_idx    = pc[ADDR_WIDTH+1:2];
  assign misaligned   = |pc[1:0];
  assign out_of_range = |pc[PC_LENGTH-1:ADDR_WIDTH+2];

  // Fetch response: busy is still low on the ldStart edge, so that fetch sees pre-load contents.
  always_comb begin
    inst_d       = MIPS_NOP;
    inst_valid_d = 1'b0;
    inst_err_d   = 1'b0;
    if (!busy && romCe) begin
      inst_valid_d = 1'b1;
      if (misaligned || out_of_range) begin
        inst_err_d = 1'b1;
      end else begin
        inst_d = mem[fetch_idx];
      end
    end
  end

  // Registered fetch outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q       <= MIPS_NOP;
      inst_valid_q <= 1'b0;
      inst_err_q   <= 1'b0;
    end else begin
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      inst_err_q   <= inst_err_d;
    end
  end

  assign inst      = inst_q;
  assign instValid = inst_valid_q;
  assign instErr   = inst_err_q;

endmodule

// File: tb/tb_inst_mem.sv
// Randomized bench for inst_mem against a word-level model of the loaded program.
// Fetch results are checked one cycle after each request edge.
// Load handshakes and overflow are checked around each program transfer.
module tb_inst_mem;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        romCe = 1'b0;
  logic [31:0] inst;
  logic        instValid, instErr;
  logic        ldStart = 1'b0, ldValid = 1'b0, ldLast = 1'b0;
  logic [7:0]  ldByte = '0;
  logic        ldReady, busy, ldOvf;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_ovf = 1'b0;
  logic [7:0]  prog [$];

  inst_mem #(.PC_LENGTH(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .romCe(romCe),
    .inst(inst), .instValid(instValid), .instErr(instErr),
    .ldStart(ldStart), .ldValid(ldValid), .ldByte(ldByte), .ldLast(ldLast),
    .ldReady(ldReady), .busy(busy), .ldOvf(ldOvf)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: the first n bytes of prog grouped into big-endian words from word 0.
  task automatic apply_model(input int n, input bit complete);
    int nw;
    logic [31:0] v;
    nw = complete ? (n + 3) / 4 : n / 4;
    m_ovf = 1'b0;
    for (int w = 0; w < nw; w++) begin
      v = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) v = v | (32'(prog[4 * w + k]) << (8 * (3 - k)));
      if (w < DEPTH) begin
        m_mem[w]   = v;
        m_known[w] = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    ldValid = 1'b1;
    ldByte  = b;
    ldLast  = last;
    tick();
    ldValid = 1'b0;
    ldLast  = 1'b0;
  endtask

  task automatic start_load();
    ldStart = 1'b1;
    tick();
    ldStart = 1'b0;
    chk("busy_rise", 32'(busy), 1);
    chk("rdy_rise", 32'(ldReady), 1);
    chk("ovf_clear", 32'(ldOvf), 0);
  endtask

  task automatic load_prog(input bit gaps);
    start_load();
    for (int i = 0; i < prog.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_byte(prog[i], i == prog.size() - 1);
    end
    apply_model(prog.size(), 1'b1);
    chk("busy_fall", 32'(busy), 0);
    chk("rdy_fall", 32'(ldReady), 0);
    chk("ovf", 32'(ldOvf), 32'(m_ovf));
  endtask

  // Presents one fetch (romCe left high) and checks the response after the edge.
  task automatic fetch(input logic [31:0] p);
    bit          exp_err;
    logic [AW-1:0] idx;
    pc    = p;
    romCe = 1'b1;
    tick();
    exp_err = (p[1:0] != 2'b00) || (p[31:AW+2] != '0);
    idx     = p[AW+1:2];
    chk("f_vld", 32'(instValid), 1);
    chk("f_err", 32'(instErr), 32'(exp_err));
    if (exp_err) chk("f_inst_nop", inst, 0);
    else if (m_known[idx]) chk("f_inst", inst, m_mem[idx]);
  endtask

  task automatic idle_fetch();
    romCe = 1'b0;
    pc    = $urandom;
    tick();
    chk("idle_vld", 32'(instValid), 0);
    chk("idle_inst", inst, 0);
    chk("idle_err", 32'(instErr), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_vld"}, 32'(instValid), 0);
    chk({tag, "_err"}, 32'(instErr), 0);
    chk({tag, "_rdy"}, 32'(ldReady), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ovf"}, 32'(ldOvf), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1 check_all_zero("rst");
    #4 rst = 1'b1;
    tick();

    // Known program, then back-to-back fetches
    prog = '{8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    load_prog(1'b1);
    fetch(32'h0);
    chk("tp_word0", inst, 32'h2401_0005);
    fetch(32'h4);
    chk("tp_word1", inst, 32'h0000_0000);
    idle_fetch();

    // Early ldLast zero-fills the word
    prog = '{8'hAB, 8'hCD};
    load_prog(1'b0);
    fetch(32'h0);
    chk("short_word", inst, 32'hABCD_0000);

    // Misaligned and out-of-range, then a good fetch clears instErr
    fetch(32'h2);
    fetch(32'h1 << (AW + 2));
    fetch(32'h0);
    chk("err_clear", 32'(instErr), 0);
    idle_fetch();

    // Same-edge ldStart+fetch returns the old word; fetches blocked during load
    pc = '0;
    romCe = 1'b1;
    ldStart = 1'b1;
    tick();
    ldStart = 1'b0;
    chk("same_edge_vld", 32'(instValid), 1);
    chk("same_edge_inst", inst, 32'hABCD_0000);
    prog.delete();
    for (int i = 0; i < 4; i++) prog.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) begin
      send_byte(prog[i], i == 3);
      chk("load_vld_blk", 32'(instValid), 0);
      chk("load_inst_blk", inst, 0);
    end
    apply_model(4, 1'b1);
    fetch(32'h0);
    idle_fetch();

    // Random programs and random fetches
    repeat (4) begin
      int n;
      n = $urandom_range(1, 40);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
      load_prog(1'b1);
      repeat (10) begin
        if ($urandom_range(0, 3) == 0) fetch($urandom);
        else fetch(32'($urandom_range(0, (n + 3) / 4 - 1)) << 2);
        if ($urandom_range(0, 2) == 0) idle_fetch();
      end
      idle_fetch();
    end

    // Overflow: depth+1 words
    prog.delete();
    for (int i = 0; i < 4 * (DEPTH + 1); i++) prog.push_back(8'($urandom));
    load_prog(1'b0);
    chk("ovf_set", 32'(ldOvf), 1);
    fetch(32'h0);
    fetch(32'(DEPTH - 1) << 2);
    repeat (10) fetch(32'($urandom_range(0, DEPTH - 1)) << 2);
    idle_fetch();

    // Next load clears ldOvf; preload words 0 and 1
    prog.delete();
    for (int i = 0; i < 8; i++) prog.push_back(8'($urandom));
    load_prog(1'b1);

    // Reset after 6 bytes: word 0 replaced, partial word 1 discarded
    prog.delete();
    for (int i = 0; i < 6; i++) prog.push_back(8'($urandom));
    start_load();
    for (int i = 0; i < 6; i++) send_byte(prog[i], 1'b0);
    apply_model(6, 1'b0);
    rst = 1'b0;
    #1 check_all_zero("midrst");
    #1 rst = 1'b1;
    fetch(32'h0);
    fetch(32'h4);
    idle_fetch();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
